// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_target_pkg;

   localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h50;
   localparam int BIT_CNT_W = 4;
   localparam logic [BIT_CNT_W-1:0] BIT_ONE = 1;
   localparam logic [BIT_CNT_W-1:0] BYTE_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_IGNORE
   } i2c_target_state_t;

endpackage

// File: rtl/i2c_target_regfile_if.sv
// Pin and write-notification bundle between the I2C bus and the register-file target.
interface i2c_target_regfile_if #(
   parameter int NREGS = 16
);
   localparam int AW = $clog2(NREGS);

   logic          i2c_scl_i;
   logic          i2c_sda_i;
   logic          i2c_sda_o;
   logic          i2c_sda_t;
   logic          busy;
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;

   modport slave (
      input  i2c_scl_i, i2c_sda_i,
      output i2c_sda_o, i2c_sda_t, busy, wr_valid, wr_addr, wr_data
   );

   modport master (
      output i2c_scl_i, i2c_sda_i,
      input  i2c_sda_o, i2c_sda_t, busy, wr_valid, wr_addr, wr_data
   );
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the clk domain and flags edges, START and STOP.
module i2c_bus_sync (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   // [0] metastable stage, [1] synchronized level, [2] previous level; idle bus reads high
   logic [2:0] scl_pipe;
   logic [2:0] sda_pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_pipe <= '1;
         sda_pipe <= '1;
      end else begin
         scl_pipe <= {scl_pipe[1:0], scl_i};
         sda_pipe <= {sda_pipe[1:0], sda_i};
      end
   end

   assign scl_rise  =  scl_pipe[1] & ~scl_pipe[2];
   assign scl_fall  = ~scl_pipe[1] &  scl_pipe[2];
   assign start_det =  scl_pipe[1] &  scl_pipe[2] &  sda_pipe[2] & ~sda_pipe[1];
   assign stop_det  =  scl_pipe[1] &  scl_pipe[2] & ~sda_pipe[2] &  sda_pipe[1];
   assign sda_s     =  sda_pipe[1];

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing a byte-wide register file with an auto-incrementing pointer.
// NREGS must match the NREGS of the connected interface instance.
module i2c_target_regfile
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
   parameter int         NREGS       = 16
) (
   input logic                 clk,
   input logic                 rst,
   i2c_target_regfile_if.slave bus
);

   localparam int PW = $clog2(NREGS);
   typedef logic [PW-1:0] ptr_t;

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   i2c_bus_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (bus.i2c_scl_i),
      .sda_i     (bus.i2c_sda_i),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   i2c_target_state_t    state, state_nx;
   logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nx;
   logic [7:0]           shift, shift_nx;
   logic                 sda_q, sda_nx;
   logic                 busy_q, busy_nx;
   logic                 rw_q, rw_nx;
   logic                 first_q, first_nx;
   ptr_t                 ptr, ptr_nx;
   logic                 wr_en;
   logic                 wr_valid_q;
   ptr_t                 wr_addr_q;
   logic [7:0]           wr_data_q;
   logic [7:0]           regs [NREGS];
   logic [7:0]           rd_byte;

   assign rd_byte = regs[ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         shift      <= '0;
         sda_q      <= 1'b1;
         busy_q     <= 1'b0;
         rw_q       <= 1'b0;
         first_q    <= 1'b0;
         ptr        <= '0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state      <= state_nx;
         bit_cnt    <= bit_cnt_nx;
         shift      <= shift_nx;
         sda_q      <= sda_nx;
         busy_q     <= busy_nx;
         rw_q       <= rw_nx;
         first_q    <= first_nx;
         ptr        <= ptr_nx;
         wr_valid_q <= wr_en;
         if (wr_en) begin
            wr_addr_q <= ptr;
            wr_data_q <= shift;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[ptr] <= shift;
      end
   end

   // Read bytes are pre-shifted: bit 7 goes out at load, bit_cnt counts bits already presented
   always_comb begin
      state_nx   = state;
      bit_cnt_nx = bit_cnt;
      shift_nx   = shift;
      sda_nx     = sda_q;
      busy_nx    = busy_q;
      rw_nx      = rw_q;
      first_nx   = first_q;
      ptr_nx     = ptr;
      wr_en      = 1'b0;
      if (start_det) begin
         state_nx   = ST_ADDR;
         bit_cnt_nx = '0;
         sda_nx     = 1'b1;
      end else if (stop_det) begin
         state_nx = ST_IDLE;
         sda_nx   = 1'b1;
         busy_nx  = 1'b0;
      end else begin
         case (state)
            ST_ADDR, ST_WR_DATA: begin
               if (scl_rise) begin
                  shift_nx   = {shift[6:0], sda_s};
                  bit_cnt_nx = bit_cnt + BIT_ONE;
               end else if (scl_fall && bit_cnt == BYTE_BITS) begin
                  if (state == ST_ADDR) begin
                     if (shift[7:1] == TARGET_ADDR) begin
                        state_nx = ST_ADDR_ACK;
                        sda_nx   = 1'b0;
                        busy_nx  = 1'b1;
                        rw_nx    = shift[0];
                     end else begin
                        state_nx = ST_IGNORE;
                        sda_nx   = 1'b1;
                        busy_nx  = 1'b0;
                     end
                  end else begin
                     state_nx = ST_WR_ACK;
                     sda_nx   = 1'b0;
                     first_nx = 1'b0;
                     if (first_q) begin
                        ptr_nx = shift[PW-1:0];
                     end else begin
                        wr_en  = 1'b1;
                        ptr_nx = ptr + ptr_t'(1);
                     end
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  bit_cnt_nx = '0;
                  sda_nx     = 1'b1;
                  if (rw_q) begin
                     state_nx   = ST_RD_DATA;
                     sda_nx     = rd_byte[7];
                     shift_nx   = {rd_byte[6:0], 1'b1};
                     ptr_nx     = ptr + ptr_t'(1);
                     bit_cnt_nx = BIT_ONE;
                  end else begin
                     state_nx = ST_WR_DATA;
                     first_nx = 1'b1;
                  end
               end
            end
            ST_WR_ACK: begin
               if (scl_fall) begin
                  state_nx   = ST_WR_DATA;
                  sda_nx     = 1'b1;
                  bit_cnt_nx = '0;
               end
            end
            ST_RD_DATA: begin
               if (scl_fall) begin
                  if (bit_cnt == '0) begin
                     sda_nx     = rd_byte[7];
                     shift_nx   = {rd_byte[6:0], 1'b1};
                     ptr_nx     = ptr + ptr_t'(1);
                     bit_cnt_nx = BIT_ONE;
                  end else if (bit_cnt == BYTE_BITS) begin
                     state_nx = ST_RD_ACK;
                     sda_nx   = 1'b1;
                  end else begin
                     sda_nx     = shift[7];
                     shift_nx   = {shift[6:0], 1'b1};
                     bit_cnt_nx = bit_cnt + BIT_ONE;
                  end
               end
            end
            ST_RD_ACK: begin
               if (scl_rise) begin
                  bit_cnt_nx = '0;
                  state_nx   = sda_s ? ST_IGNORE : ST_RD_DATA;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.i2c_sda_o = sda_q;
   assign bus.i2c_sda_t = sda_q;
   assign bus.busy      = busy_q;
   assign bus.wr_valid  = wr_valid_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: a bit-banged I2C master drives directed and random
// transactions, and a byte-level register/pointer model predicts ACKs, read data and write pulses.
module tb_i2c_target_regfile;

   localparam int         NREGS = 16;
   localparam int         AW    = $clog2(NREGS);
   localparam int         QTR   = 6;
   localparam logic [6:0] TADDR = 7'h50;

   logic clk = 1'b0;
   logic rst;
   logic scl_drv;
   logic sda_drv;
   logic sda_line;

   i2c_target_regfile_if #(.NREGS(NREGS)) bus ();

   i2c_target_regfile #(.TARGET_ADDR(TADDR), .NREGS(NREGS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Open-drain bus: the line is low if either side pulls it low
   assign sda_line      = sda_drv & (bus.i2c_sda_t | bus.i2c_sda_o);
   assign bus.i2c_scl_i = scl_drv;
   assign bus.i2c_sda_i = sda_line;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [7:0]    m_regs [NREGS];
   int            m_ptr;
   logic [7:0]    tx_q[$];
   logic [AW+7:0] exp_q[$];
   logic [AW+7:0] obs_q[$];
   int            chk_idx = 0;
   int            busy_cycles = 0;
   int            wv_run = 0;
   int            wv_long = 0;

   always @(negedge clk) begin
      if (bus.wr_valid) begin
         obs_q.push_back({bus.wr_addr, bus.wr_data});
         wv_run = wv_run + 1;
         if (wv_run > 1) wv_long = wv_long + 1;
      end else begin
         wv_run = 0;
      end
      if (bus.busy) busy_cycles = busy_cycles + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2cStart();
      sda_drv = 1'b1; waitClk(QTR);
      scl_drv = 1'b1; waitClk(QTR);
      sda_drv = 1'b0; waitClk(QTR);
      scl_drv = 1'b0; waitClk(QTR);
   endtask

   task automatic i2cStop();
      sda_drv = 1'b0; waitClk(QTR);
      scl_drv = 1'b1; waitClk(QTR);
      sda_drv = 1'b1; waitClk(QTR);
   endtask

   task automatic writeBit(input bit b);
      sda_drv = b;    waitClk(QTR);
      scl_drv = 1'b1; waitClk(2 * QTR);
      scl_drv = 1'b0; waitClk(QTR);
   endtask

   task automatic readBit(output bit b);
      sda_drv = 1'b1; waitClk(QTR);
      scl_drv = 1'b1; waitClk(QTR);
      b = sda_line;   waitClk(QTR);
      scl_drv = 1'b0; waitClk(QTR);
   endtask

   task automatic writeByte(input logic [7:0] d, output bit ack);
      bit b;
      for (int i = 7; i >= 0; i--) writeBit(d[i]);
      readBit(b);
      ack = !b;
   endtask

   task automatic readByte(output logic [7:0] d, input bit ack);
      bit b;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         readBit(b);
         d = {d[6:0], b};
      end
      writeBit(!ack);
   endtask

   task automatic checkWrites();
      checkOutput("wr_count", obs_q.size(), exp_q.size());
      for (int i = chk_idx; i < exp_q.size() && i < obs_q.size(); i++)
         checkOutput("wr_pulse", obs_q[i], exp_q[i]);
      chk_idx = exp_q.size();
   endtask

   // Write transaction: first byte after the address is the pointer, the rest are data
   task automatic doWrite(input logic [6:0] addr7);
      bit ack;
      bit match;
      bit first;
      int busy_start;
      match      = (addr7 == TADDR);
      busy_start = busy_cycles;
      first      = 1'b1;
      i2cStart();
      writeByte({addr7, 1'b0}, ack);
      checkOutput("wr_addr_ack", ack, match);
      foreach (tx_q[i]) begin
         writeByte(tx_q[i], ack);
         checkOutput("wr_data_ack", ack, match);
         if (match) begin
            if (first) begin
               m_ptr = tx_q[i] % NREGS;
            end else begin
               exp_q.push_back({AW'(m_ptr), tx_q[i]});
               m_regs[m_ptr] = tx_q[i];
               m_ptr = (m_ptr + 1) % NREGS;
            end
            first = 1'b0;
         end
      end
      i2cStop();
      waitClk(8);
      checkOutput("wr_busy_end", bus.busy, 0);
      checkOutput("wr_busy_seen", busy_cycles != busy_start, match);
      checkWrites();
      tx_q.delete();
   endtask

   // Read transaction, optionally preceded by a pointer write and a repeated START
   task automatic doRead(input bit set_ptr, input logic [7:0] ptr_byte, input logic [6:0] addr7, input int n);
      bit         ack;
      bit         match;
      logic [7:0] data;
      match = (addr7 == TADDR);
      i2cStart();
      if (set_ptr) begin
         writeByte({TADDR, 1'b0}, ack);
         checkOutput("rd_setup_ack", ack, 1);
         writeByte(ptr_byte, ack);
         checkOutput("rd_ptr_ack", ack, 1);
         m_ptr = ptr_byte % NREGS;
         i2cStart();
      end
      writeByte({addr7, 1'b1}, ack);
      checkOutput("rd_addr_ack", ack, match);
      if (match) begin
         for (int i = 0; i < n; i++) begin
            readByte(data, i != n - 1);
            checkOutput("rd_data", data, m_regs[m_ptr]);
            m_ptr = (m_ptr + 1) % NREGS;
         end
         waitClk(4);
         checkOutput("rd_nack_release", bus.i2c_sda_t, 1);
      end
      i2cStop();
      waitClk(8);
      checkOutput("rd_busy_end", bus.busy, 0);
      checkWrites();
   endtask

   task automatic applyStimulus(input int n_trans);
      int         kind;
      int         nbytes;
      logic [6:0] addr7;
      for (int t = 0; t < n_trans; t++) begin
         kind  = $urandom_range(0, 2);
         addr7 = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : TADDR;
         case (kind)
            0: begin
               nbytes = $urandom_range(0, 4);
               tx_q.push_back(8'($urandom));
               for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom));
               doWrite(addr7);
            end
            1: doRead(1'b1, 8'($urandom), addr7, $urandom_range(1, 3));
            default: doRead(1'b0, 8'h00, addr7, $urandom_range(1, 3));
         endcase
      end
   endtask

   initial begin
      bit b;
      bit ack;
      rst     = 1'b1;
      scl_drv = 1'b1;
      sda_drv = 1'b1;
      m_ptr   = 0;
      for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
      waitClk(4);
      checkOutput("reset_sda_o", bus.i2c_sda_o, 1);
      checkOutput("reset_sda_t", bus.i2c_sda_t, 1);
      checkOutput("reset_busy", bus.busy, 0);
      checkOutput("reset_wr_valid", bus.wr_valid, 0);
      checkOutput("reset_wr_addr", bus.wr_addr, 0);
      checkOutput("reset_wr_data", bus.wr_data, 0);
      rst = 1'b0;
      waitClk(4);

      $display("[TB] write burst");
      tx_q = '{8'h03, 8'h11, 8'h22};
      doWrite(TADDR);

      $display("[TB] read with repeated START");
      doRead(1'b1, 8'h03, TADDR, 2);

      $display("[TB] pointer wrap-around");
      tx_q = '{8'h0F, 8'hAA, 8'hBB};
      doWrite(TADDR);
      doRead(1'b1, 8'h0F, TADDR, 2);

      $display("[TB] address mismatch");
      tx_q = '{8'h55};
      doWrite(7'h51);

      $display("[TB] abort mid-byte");
      tx_q = '{8'h07, 8'h77, 8'h88};
      doWrite(TADDR);
      i2cStart();
      writeByte({TADDR, 1'b0}, ack);
      checkOutput("abort_addr_ack", ack, 1);
      writeByte(8'h07, ack);
      checkOutput("abort_ptr_ack", ack, 1);
      m_ptr = 7;
      writeBit(1'b1); writeBit(1'b0); writeBit(1'b1); writeBit(1'b0);
      i2cStop();
      waitClk(8);
      checkOutput("abort_busy", bus.busy, 0);
      checkWrites();
      doRead(1'b0, 8'h00, TADDR, 1);

      $display("[TB] reset during read");
      i2cStart();
      writeByte({TADDR, 1'b0}, ack);
      writeByte(8'h00, ack);
      m_ptr = 0;
      i2cStart();
      writeByte({TADDR, 1'b1}, ack);
      checkOutput("mid_addr_ack", ack, 1);
      readBit(b);
      checkOutput("mid_bit7", b, m_regs[0][7]);
      checkOutput("mid_sda_low", sda_line, m_regs[0][6]);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("rst_sda_t", bus.i2c_sda_t, 1);
      checkOutput("rst_sda_o", bus.i2c_sda_o, 1);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_wr_addr", bus.wr_addr, 0);
      checkOutput("rst_wr_data", bus.wr_data, 0);
      for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
      m_ptr = 0;
      waitClk(3);
      rst = 1'b0;
      waitClk(2);
      i2cStop();
      waitClk(4);
      doRead(1'b1, 8'h00, TADDR, 1);

      $display("[TB] random transactions");
      applyStimulus(12);

      checkOutput("wr_valid_width", wv_long, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
